// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared ALU constants and sign-magnitude helper
package mul_seq_pkg;

    // Default operand width for the iterative ALU units.
    localparam int WIDTH_DEFAULT = 32;

    // Working width of the negate helper; callers must keep 2*WIDTH within it.
    localparam int MAG_W = 128;

    // FSM encoding shared with the iterative divider.
    typedef logic [1:0] state_t;
    localparam logic [1:0] S_IDLE      = 2'b00;
    localparam logic [1:0] S_COMPUTING = 2'b01;
    localparam logic [1:0] S_FIXUP     = 2'b10;

    // Conditional two's-complement negate. With neg = signed & msb this gives
    // |x|; with neg = result sign it restores the signed result. Callers
    // zero-extend into MAG_W bits and size-cast the result back, so the
    // low bits are exact modulo 2^width.
    function automatic logic [MAG_W-1:0] cond_neg(input logic [MAG_W-1:0] x,
                                                  input logic neg);
        return neg ? (~x + MAG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one combinational radix-2 shift-add iteration
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_mcand,
    output logic [WIDTH-1:0]   o_mplier,
    output logic               o_last
);

    // Add the shifted multiplicand when the current multiplier bit is set.
    assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;

    // Multiplicand never exceeds 2^WIDTH and shifts at most WIDTH-1 more
    // times while it can still be added, so dropping the top bit is safe.
    assign o_mcand  = i_mcand << 1;
    assign o_mplier = i_mplier >> 1;

    // Early exit: no set bits remain in the multiplier after this step.
    assign o_last   = (o_mplier == '0);

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative radix-2 shift-add multiplier with start/busy handshake
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signedness,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;

    logic [1:0]       r_state;
    logic             r_sign;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [PW-1:0]    w_acc_nxt;
    logic [PW-1:0]    w_mcand_nxt;
    logic [WIDTH-1:0] w_mplier_nxt;
    logic             w_last;
    logic [PW-1:0]    w_prod;

    // Operand magnitudes; the most-negative value maps onto itself and is
    // then read as unsigned, which is the correct magnitude.
    assign w_abs_a = WIDTH'(cond_neg(MAG_W'(a), signedness & a[WIDTH-1]));
    assign w_abs_b = WIDTH'(cond_neg(MAG_W'(b), signedness & b[WIDTH-1]));

    // Final signed product; -0 = 0 so a zero result needs no special case.
    assign w_prod  = PW'(cond_neg(MAG_W'(r_acc), r_sign));

    mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_nxt),
        .o_mcand  (w_mcand_nxt),
        .o_mplier (w_mplier_nxt),
        .o_last   (w_last)
    );

    // Sequencer: capture operands, iterate until the multiplier empties, then sign-fix.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sign   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign   <= signedness & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= PW'(w_abs_a);
                        r_mplier <= w_abs_b;
                        r_acc    <= '0;
                        r_state  <= (w_abs_b != '0) ? S_COMPUTING : S_FIXUP;
                    end
                end
                S_COMPUTING: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= w_mcand_nxt;
                    r_mplier <= w_mplier_nxt;
                    if (w_last) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_hi    <= w_prod[PW-1:WIDTH];
                    r_lo    <= w_prod[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed self-checking bench for mul_seq
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signedness;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    mul_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signedness (signedness),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Pulse start with the given operands and count busy cycles after the start edge.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          output int cyc, output logic dn, output logic held);
        logic [31:0] ph;
        logic [31:0] pl;
        ph = hi;
        pl = lo;
        held = 1'b1;
        @(negedge clk);
        a = ta; b = tb_v; signedness = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (hi !== ph || lo !== pl) held = 1'b0;
            @(negedge clk);
        end
        dn = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; signedness = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
    endtask

    task automatic test_unsigned_small();
        int c; logic d; logic h;
        run_op(32'd7, 32'd6, 1'b0, c, d, h);
        n_cmp++; if (c !== 4) begin n_bad++; $display("FAIL u7x6_busy got %0d want 4", c); end
        n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL u7x6_done got %b want 1", d); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL u7x6_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h2A) begin n_bad++; $display("FAIL u7x6_lo got %h want 0000002a", lo); end
        n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL u7x6_hold got %b want 1", h); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got %b want 0", done); end
    endtask

    task automatic test_signed_small();
        int c; logic d; logic h;
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, c, d, h);
        n_cmp++; if (c !== 4) begin n_bad++; $display("FAIL sm3x5_busy got %0d want 4", c); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sm3x5_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL sm3x5_lo got %h want fffffff1", lo); end
        n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL sm3x5_hold got %b want 1", h); end
    endtask

    task automatic test_full_width();
        int c; logic d; logic h;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, c, d, h);
        n_cmp++; if (c !== 33) begin n_bad++; $display("FAIL umax_busy got %0d want 33", c); end
        n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL umax_done got %b want 1", d); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL umax_hi got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL umax_lo got %h want 00000001", lo); end
        n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL umax_hold got %b want 1", h); end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, c, d, h);
        n_cmp++; if (c !== 2) begin n_bad++; $display("FAIL sm1_busy got %0d want 2", c); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL sm1_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h1) begin n_bad++; $display("FAIL sm1_lo got %h want 00000001", lo); end
    endtask

    task automatic test_most_negative();
        int c; logic d; logic h;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, c, d, h);
        n_cmp++; if (c !== 33) begin n_bad++; $display("FAIL mnsq_busy got %0d want 33", c); end
        n_cmp++; if (hi !== 32'h4000_0000) begin n_bad++; $display("FAIL mnsq_hi got %h want 40000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL mnsq_lo got %h want 00000000", lo); end
        run_op(32'h8000_0000, 32'd1, 1'b1, c, d, h);
        n_cmp++; if (c !== 2) begin n_bad++; $display("FAIL mnx1_busy got %0d want 2", c); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mnx1_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL mnx1_lo got %h want 80000000", lo); end
    endtask

    task automatic test_zero_multiplier();
        int c; logic d; logic h;
        run_op(32'h1234, 32'd0, 1'b0, c, d, h);
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL bzero_busy got %0d want 1", c); end
        n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL bzero_done got %b want 1", d); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL bzero_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL bzero_lo got %h want 00000000", lo); end
    endtask

    task automatic test_back_to_back();
        int c;
        @(negedge clk);
        a = 32'd5; b = 32'd7; signedness = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        c = 0;
        while (busy === 1'b1 && c < 200) begin
            c++;
            if (c == 1) begin
                a = 32'd2; b = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0; a = '0; b = '0;
            end
            @(negedge clk);
        end
        n_cmp++; if (c !== 4) begin n_bad++; $display("FAIL ignore_busy got %0d want 4", c); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ignore_done got %b want 1", done); end
        n_cmp++; if (lo !== 32'h23) begin n_bad++; $display("FAIL ignore_lo got %h want 00000023", lo); end
        a = 32'd2; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        c = 0;
        while (busy === 1'b1 && c < 200) begin
            c++;
            @(negedge clk);
        end
        n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL donecyc_busy got %0d want 3", c); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL donecyc_done got %b want 1", done); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL donecyc_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h6) begin n_bad++; $display("FAIL donecyc_lo got %h want 00000006", lo); end
    endtask

    task automatic test_reset_mid_op();
        int c; logic d; logic h;
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; signedness = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        repeat (9) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midop_busy got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL abort_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL abort_lo got %h want 00000000", lo); end
        reset = 1'b0;
        run_op(32'd3, 32'd3, 1'b0, c, d, h);
        n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL post_busy got %0d want 3", c); end
        n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL post_done got %b want 1", d); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL post_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h9) begin n_bad++; $display("FAIL post_lo got %h want 00000009", lo); end
    endtask

    initial begin
        test_reset();
        test_unsigned_small();
        test_signed_small();
        test_full_width();
        test_most_negative();
        test_zero_multiplier();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative radix-2 shift-add multiplier; the inverse-operation companion to the team's iterative divider in the ALU.
- Accepts two WIDTH-bit operands with a start pulse and a signedness flag, and produces a 2*WIDTH-bit product split into hi/lo words.
- Uses the same start/busy handshake as the divider.
- Exits early once the remaining multiplier bits are zero.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- signedness  input  1  1 = both operands two's-complement signed; 0 = both unsigned.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse, high in the cycle the result first appears on hi/lo.
- hi  output  WIDTH  upper half of the product.
- lo  output  WIDTH  lower half of the product.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; all internal registers cleared.
  - A reset asserted mid-operation aborts it: next cycle is IDLE, outputs are zero, no done pulse.
- States: IDLE, COMPUTING, FIXUP. busy = (state != IDLE).
- IDLE with start=1, on the clock edge:
  - sign <= signedness & (a[MSB] ^ b[MSB]).
  - mcand (2*WIDTH bits) <= zero-extended |a|, where |x| = -x if signedness & x[MSB], else x.
  - mplier (WIDTH bits) <= |b|; acc (2*WIDTH bits) <= 0.
  - Next state is COMPUTING if |b| != 0, else FIXUP.
  - Operands need not be held after this edge.
- COMPUTING, each cycle:
  - If mplier[0], acc <= acc + mcand (mod 2^(2*WIDTH)).
  - mcand <= mcand << 1; mplier <= mplier >> 1.
  - Next state is FIXUP when (mplier >> 1) == 0, else COMPUTING.
- FIXUP:
  - {hi,lo} <= sign ? -acc : acc (2*WIDTH-bit two's complement); done=1 this cycle; next state IDLE.
- Latency:
  - Let k = index of the highest set bit of |b| plus 1, with k=0 for |b|=0.
  - busy is high for exactly k+1 cycles after the start edge; the maximum is WIDTH+1.
  - done coincides with the first IDLE cycle after FIXUP, i.e. the cycle busy falls.
- hi/lo hold the previous result for the whole operation and change only at the FIXUP edge. They then hold until the next FIXUP or reset.
- start while busy=1 is ignored; there is no queueing.
- start in the same cycle done=1 (state IDLE) is accepted normally.
- Edge cases:
  - Signed most-negative operand: |0x80000000| = 0x80000000 treated as unsigned. The product always fits 2*WIDTH bits, so there is no overflow.
  - a=0 with b!=0: full k iterations, result 0, sign forced irrelevant because -0 = 0.

Decomposition:
- Shared ALU package:
  - State encoding constants (IDLE=2'b00, COMPUTING=2'b01, FIXUP=2'b10).
  - Default WIDTH.
  - A magnitude/negate function, shared with the divider's sign handling.
- One natural sub-module: mul_step, a combinational single shift-add iteration.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, next mcand, next mplier, and a last flag.

Test Plan:
- Unsigned a=7, b=6, start pulse -> busy high 4 cycles; done pulse; hi=0x00000000, lo=0x0000002A.
- Signed a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy 4 cycles.
- Unsigned a=b=0xFFFFFFFF -> busy 33 cycles; hi=0xFFFFFFFE, lo=0x00000001. Same operands signed (-1*-1) -> hi=0, lo=1.
- Signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Signed a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- b=0, a=0x1234 -> busy exactly 1 cycle, hi=lo=0. A second start (a=2, b=3) pulsed while busy is ignored; start held in the done cycle launches the new operation.
- Start a=0xFFFFFFFF, b=0xFFFFFFFF, assert reset at cycle 10 -> next cycle busy=0, done=0, hi=lo=0. Then a new op a=3, b=3 -> lo=9.
